// File: rtl/phy_tx_multilane.sv
// phy_tx_multilane
//   Single-clock multi-lane serial PHY transmitter. Input words are striped
//   round-robin over LANES lanes. Each lane buffers words in a small FIFO and
//   serialises one bit per clk. All lanes share one bit counter, so their
//   frames stay aligned. A lane with no buffered word sends IDLE_WORD, which
//   is IDLE_BYTE repeated across the word.
//
//   Optional build macro: PHY_TX_LSB_FIRST_EN
//     When defined, each frame is sent LSB first; otherwise MSB first.
//     Timing, valid and frame_start are the same in both builds.
//
// Ports
//   clk_i                 single clock, rising edge
//   reset_i               synchronous reset, active high
//   data_in_tx_i          input word (DATA_W)
//   valid_in_tx_i         data_in_tx_i is valid
//   ready_out_tx_o        block can accept a word; transfer = valid & ready
//   data_out_lane_tx_o    serial bit per lane (bit l = lane l)
//   valid_out_lane_tx_o   lane carries a data word this frame (0 = idle word)
//   frame_start_tx_o      high on the first bit of every frame

// One lane: FIFO plus shift register.
module phy_tx_lane #(
    parameter int              DATA_W     = 32,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              load_i,   // last bit of frame: reload shreg next edge
    output logic              full_o,
    output logic              bit_o,
    output logic              valid_o
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q, count_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              valid_q, valid_d;
    logic              pop;

    // Pop uses the pre-push count, so a word pushed into an empty FIFO on the
    // frame boundary edge waits for the following frame.
    assign pop    = load_i && (count_q != '0);
    assign full_o = (count_q == (PW+1)'(FIFO_DEPTH));

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        shreg_d = shreg_q;
        valid_d = valid_q;
        if (load_i) begin
            shreg_d = pop ? mem_q[rd_ptr_q] : IDLE_WORD;
            valid_d = pop;
        end else begin
`ifdef PHY_TX_LSB_FIRST_EN
            shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
`else
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
`endif
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shreg_q  <= IDLE_WORD;
            valid_q  <= 1'b0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            shreg_q <= shreg_d;
            valid_q <= valid_d;
        end
    end

`ifdef PHY_TX_LSB_FIRST_EN
    assign bit_o = shreg_q[0];
`else
    assign bit_o = shreg_q[DATA_W-1];
`endif
    assign valid_o = valid_q;
endmodule

module phy_tx_multilane #(
    parameter int          DATA_W     = 32,
    parameter int          LANES      = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  IDLE_BYTE  = 8'hBC
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] data_in_tx_i,
    input  logic              valid_in_tx_i,
    output logic              ready_out_tx_o,
    output logic [LANES-1:0]  data_out_lane_tx_o,
    output logic [LANES-1:0]  valid_out_lane_tx_o,
    output logic              frame_start_tx_o
);
    localparam int CW = $clog2(DATA_W);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [DATA_W-1:0] IDLE_WORD = {(DATA_W/8){IDLE_BYTE}};

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    lane_sel_q, lane_sel_d;
    logic [LANES-1:0] full;
    logic             xfer, frame_end;

    assign frame_end      = (cnt_q == CW'(DATA_W-1));
    assign cnt_d          = frame_end ? '0 : cnt_q + 1'b1;
    assign ready_out_tx_o = !reset_i && !full[lane_sel_q];
    assign xfer           = valid_in_tx_i && ready_out_tx_o;
    // Strict round-robin: a full lane stalls input rather than being skipped.
    assign lane_sel_d     = !xfer ? lane_sel_q :
                            (lane_sel_q == LW'(LANES-1)) ? '0 : lane_sel_q + 1'b1;
    assign frame_start_tx_o = (cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            lane_sel_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            lane_sel_q <= lane_sel_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        phy_tx_lane #(
            .DATA_W    (DATA_W),
            .FIFO_DEPTH(FIFO_DEPTH),
            .IDLE_WORD (IDLE_WORD)
        ) u_lane (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .push_i (xfer && (lane_sel_q == LW'(l))),
            .din_i  (data_in_tx_i),
            .load_i (frame_end),
            .full_o (full[l]),
            .bit_o  (data_out_lane_tx_o[l]),
            .valid_o(valid_out_lane_tx_o[l])
        );
    end
endmodule
